// File: rtl/pcl_pkg.sv
// Shared types for the 65c02 program-counter low byte.
// States of the branch-fixup FSM and the pending PCH adjustment.
package pcl_pkg;

  typedef enum logic {
    PCL_IDLE,
    PCL_FIXUP
  } pcl_state_t;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_CARRY,
    PEND_BORROW
  } pcl_pend_t;

  localparam int PCL_W = 8;

endpackage

// File: rtl/pcl_branch_adder.sv
// Relative-branch adder for PCL.
// Flags a page crossing in either direction.
module pcl_branch_adder
  import pcl_pkg::*;
(
  input  logic [PCL_W-1:0] pcl,
  input  logic [PCL_W-1:0] offset,
  output logic [PCL_W-1:0] sum,
  output logic             carry_pend,
  output logic             borrow_pend
);

  logic [PCL_W:0] sum9;

  // Unsigned 9-bit add; bit 8 tells us the page outcome
  always_comb begin
    sum9        = {1'b0, pcl} + {1'b0, offset};
    sum         = sum9[PCL_W-1:0];
    carry_pend  = !offset[PCL_W-1] && sum9[PCL_W];
    borrow_pend = offset[PCL_W-1] && !sum9[PCL_W];
  end

endmodule

// File: rtl/pcl_unit.sv
// 65c02 PCL register, PCH carry/borrow producer, branch fixup stall.
// Optional opcode-address shadow enabled by macro PCL_SHADOW_EN.
module pcl_unit
  import pcl_pkg::*;
#(
  parameter logic [7:0] RESET_PCL = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pcl_load,
  input  logic [7:0] db_in,
  input  logic       adl_load,
  input  logic [7:0] adl_in,
  input  logic       branch_take,
  input  logic [7:0] branch_offset,
  input  logic       pcl_inc,
  input  logic       sync,
  output logic [7:0] db_out,
  output logic [7:0] address_low_out,
  output logic       carry_to_pch,
  output logic       borrow_to_pch,
  output logic       fixup_busy,
  output logic [7:0] pcl_shadow
);

  pcl_state_t state, state_next;
  pcl_pend_t  pend_next;
  logic [7:0] pcl, pcl_next;
  logic [7:0] br_sum;
  logic       br_carry, br_borrow;
  logic       carry_q, borrow_q;

  pcl_branch_adder u_adder (
    .pcl         (pcl),
    .offset      (branch_offset),
    .sum         (br_sum),
    .carry_pend  (br_carry),
    .borrow_pend (br_borrow)
  );

  // Next PCL, next state and the pulse to issue next cycle
  always_comb begin
    state_next = PCL_IDLE;
    pend_next  = PEND_NONE;
    pcl_next   = pcl;
    if (pcl_load) begin
      pcl_next = db_in;
    end else if (adl_load) begin
      pcl_next = adl_in;
    end else if (state == PCL_IDLE && branch_take) begin
      pcl_next = br_sum;
      if (br_carry) begin
        pend_next  = PEND_CARRY;
        state_next = PCL_FIXUP;
      end else if (br_borrow) begin
        pend_next  = PEND_BORROW;
        state_next = PCL_FIXUP;
      end
    end else if (state == PCL_IDLE && pcl_inc) begin
      pcl_next = pcl + 8'd1;
      if (pcl == 8'hFF) pend_next = PEND_CARRY;
    end
  end

  // State, PCL and registered one-cycle PCH pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= PCL_IDLE;
      pcl      <= RESET_PCL;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state    <= state_next;
      pcl      <= pcl_next;
      carry_q  <= (pend_next == PEND_CARRY);
      borrow_q <= (pend_next == PEND_BORROW);
    end
  end

  assign db_out          = pcl;
  assign address_low_out = pcl;
  assign carry_to_pch    = carry_q;
  assign borrow_to_pch   = borrow_q;
  assign fixup_busy      = (state == PCL_FIXUP);

`ifdef PCL_SHADOW_EN
  logic [7:0] shadow_q;

  // Capture opcode address low byte on fetch cycles
  always_ff @(posedge clk) begin
    if (!reset_n) shadow_q <= RESET_PCL;
    else if (sync) shadow_q <= pcl;
  end

  assign pcl_shadow = shadow_q;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign pcl_shadow  = 8'h00;
`endif

endmodule

// File: tb/tb_pcl_unit.sv
// Directed bench for pcl_unit with a signed-arithmetic reference model.
// Model checked every cycle plus literal expectations.
module tb_pcl_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pcl_load, adl_load, branch_take, pcl_inc, sync;
  logic [7:0] db_in, adl_in, branch_offset;
  logic [7:0] db_out, address_low_out, pcl_shadow;
  logic       carry_to_pch, borrow_to_pch, fixup_busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  int m_pcl;
  int m_shadow;
  bit m_fix, m_carry, m_borrow;

  pcl_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pcl_load        (pcl_load),
    .db_in           (db_in),
    .adl_load        (adl_load),
    .adl_in          (adl_in),
    .branch_take     (branch_take),
    .branch_offset   (branch_offset),
    .pcl_inc         (pcl_inc),
    .sync            (sync),
    .db_out          (db_out),
    .address_low_out (address_low_out),
    .carry_to_pch    (carry_to_pch),
    .borrow_to_pch   (borrow_to_pch),
    .fixup_busy      (fixup_busy),
    .pcl_shadow      (pcl_shadow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works in signed integer page arithmetic
  always @(posedge clk) begin
    int tgt;
    int old_pcl;
    bit was_fix;
    old_pcl = m_pcl;
    was_fix = m_fix;
    if (!reset_n) begin
      m_pcl = 0; m_fix = 0; m_carry = 0; m_borrow = 0; m_shadow = 0;
    end else begin
      m_carry = 0; m_borrow = 0; m_fix = 0;
`ifdef PCL_SHADOW_EN
      if (sync) m_shadow = old_pcl;
`endif
      if (pcl_load) m_pcl = int'(db_in);
      else if (adl_load) m_pcl = int'(adl_in);
      else if (!was_fix && branch_take) begin
        tgt = old_pcl + int'($signed(branch_offset));
        if (tgt > 255) begin m_carry = 1; m_fix = 1; end
        if (tgt < 0) begin m_borrow = 1; m_fix = 1; end
        m_pcl = (tgt + 256) % 256;
      end else if (!was_fix && pcl_inc) begin
        if (old_pcl == 255) m_carry = 1;
        m_pcl = (old_pcl + 1) % 256;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_db_out", int'(db_out), m_pcl);
      check("m_adl_out", int'(address_low_out), m_pcl);
      check("m_carry", int'(carry_to_pch), int'(m_carry));
      check("m_borrow", int'(borrow_to_pch), int'(m_borrow));
      check("m_fixup", int'(fixup_busy), int'(m_fix));
      check("m_shadow", int'(pcl_shadow), m_shadow);
    end
  end

  task automatic drive(input logic pl, input logic [7:0] db,
                       input logic al, input logic [7:0] ad,
                       input logic br, input logic [7:0] off,
                       input logic inc, input logic sy);
    @(negedge clk);
    pcl_load = pl; db_in = db; adl_load = al; adl_in = ad;
    branch_take = br; branch_offset = off; pcl_inc = inc; sync = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic load(input logic [7:0] v);
    drive(1, v, 0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic lit(input string name, input int pcl_e, input int c_e,
                     input int b_e, input int f_e);
    check({name, "_pcl"}, int'(db_out), pcl_e);
    check({name, "_carry"}, int'(carry_to_pch), c_e);
    check({name, "_borrow"}, int'(borrow_to_pch), b_e);
    check({name, "_fix"}, int'(fixup_busy), f_e);
  endtask

  initial begin
    reset_n = 0;
    pcl_load = 0; adl_load = 0; branch_take = 0; pcl_inc = 0; sync = 0;
    db_in = 0; adl_in = 0; branch_offset = 0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 8'h00, 0, 0, 0);
    check("reset_shadow", int'(pcl_shadow), 0);
    @(negedge clk);
    reset_n = 1;
    cmp_en = 1;

    load(8'hFE);
    lit("ld_fe", 8'hFE, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0);
    lit("inc_ff", 8'hFF, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0);
    lit("inc_wrap", 8'h00, 1, 0, 0);
    idle();
    lit("inc_after", 8'h00, 0, 0, 0);

    drive(0, 8'h00, 1, 8'hF0, 0, 8'h00, 0, 0);
    lit("adl_f0", 8'hF0, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h20, 0, 0);
    lit("fwd_cross", 8'h10, 1, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 0);
    lit("fwd_ignored", 8'h10, 0, 0, 0);

    load(8'h10);
    drive(0, 8'h00, 0, 8'h00, 1, 8'hE0, 0, 0);
    lit("bwd_cross", 8'hF0, 0, 1, 1);
    idle();
    lit("bwd_after", 8'hF0, 0, 0, 0);

    load(8'h10);
    drive(0, 8'h00, 0, 8'h00, 1, 8'hF0, 0, 0);
    lit("same_page", 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h7F, 0, 0);
    lit("fwd_7f", 8'h7F, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h81, 0, 0);
    lit("bwd_81", 8'h00, 0, 0, 0);

    drive(1, 8'h5A, 1, 8'h77, 1, 8'h01, 1, 0);
    lit("prio_all", 8'h5A, 0, 0, 0);
    drive(0, 8'h00, 1, 8'h77, 1, 8'h01, 1, 0);
    lit("prio_adl", 8'h77, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'hFF, 1, 0);
    lit("prio_br", 8'h76, 0, 0, 0);

    load(8'hF0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h20, 0, 0);
    lit("fix_pulse", 8'h10, 1, 0, 1);
    load(8'hC3);
    lit("fix_load", 8'hC3, 0, 0, 0);
    load(8'h08);
    drive(0, 8'h00, 0, 8'h00, 1, 8'hF0, 0, 0);
    lit("fix2_pulse", 8'hF8, 0, 1, 1);
    drive(0, 8'h00, 1, 8'h44, 0, 8'h00, 0, 0);
    lit("fix_adl", 8'h44, 0, 0, 0);

    load(8'h05);
    drive(0, 8'h00, 0, 8'h00, 1, 8'hF0, 0, 0);
    lit("rst_pre", 8'hF5, 0, 1, 1);
    @(negedge clk);
    reset_n = 0;
    branch_take = 0;
    @(posedge clk);
    #1;
    lit("rst_fix", 8'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1;

    load(8'h33);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1);
`ifdef PCL_SHADOW_EN
    check("shadow_33", int'(pcl_shadow), 8'h33);
`else
    check("shadow_off", int'(pcl_shadow), 8'h00);
`endif
    lit("sync_inc", 8'h34, 0, 0, 0);
    idle();
    idle();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
